// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential 16-bit divider.
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_ITERS = 16;
  localparam logic [15:0] DIV_BYZERO_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_16bit_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider_16bit.
`default_nettype none

interface seq_divider_16bit_if;
  import div_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/carry_lookahead_adder_16bit.sv
// 16-bit two-level carry-lookahead adder/subtractor (4-bit groups).
// In subtract mode cout is the no-borrow flag.
`default_nettype none

module carry_lookahead_adder_16bit (
  input  wire logic [15:0] i_in0,
  input  wire logic [15:0] i_in1,
  input  wire logic        i_sub,
  input  wire logic        i_cin,
  output logic      [15:0] o_sum,
  output logic             o_cout,
  output logic             o_v
);

  logic [15:0] w_b;
  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [16:0] w_c;
  logic [4:0]  w_gc;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;

  // Subtract is in0 + ~in1 + 1, so the effective carry-in is inverted by sub.
  assign w_b     = i_in1 ^ {16{i_sub}};
  assign w_p     = i_in0 ^ w_b;
  assign w_g     = i_in0 & w_b;
  assign w_gc[0] = i_cin ^ i_sub;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_group
      localparam int c_B = 4 * gi;

      assign w_gp[gi] = &w_p[c_B +: 4];
      assign w_gg[gi] = w_g[c_B+3]
                      | (w_p[c_B+3] & w_g[c_B+2])
                      | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                      | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B]);

      assign w_c[c_B]   = w_gc[gi];
      assign w_c[c_B+1] = w_g[c_B] | (w_p[c_B] & w_gc[gi]);
      assign w_c[c_B+2] = w_g[c_B+1]
                        | (w_p[c_B+1] & w_g[c_B])
                        | (w_p[c_B+1] & w_p[c_B] & w_gc[gi]);
      assign w_c[c_B+3] = w_g[c_B+2]
                        | (w_p[c_B+2] & w_g[c_B+1])
                        | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                        | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_gc[gi]);
    end
  endgenerate

  assign w_gc[1] = w_gg[0] | (w_gp[0] & w_gc[0]);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_gc[0]);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & w_gc[0]);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_gc[0]);
  assign w_c[16] = w_gc[4];

  assign o_sum  = w_p ^ w_c[15:0];
  assign o_cout = w_c[16];
  assign o_v    = w_c[15] ^ w_c[16];

endmodule

`default_nettype wire

// File: rtl/seq_divider_16bit.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per clock
// through a shared carry-lookahead subtractor, start/busy/done handshake.
`default_nettype none

module seq_divider_16bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input wire logic           clk,
  input wire logic           rst,
  seq_divider_16bit_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE   = 2'(DIV_IDLE);
  localparam logic [1:0] c_ST_RUN    = 2'(DIV_RUN);
  localparam logic [1:0] c_ST_DONE   = 2'(DIV_DONE);
  localparam logic [3:0] c_LAST_ITER = 4'(DIV_ITERS - 1);

  generate
    if (WIDTH != 16) begin : g_bad_width
      $error("seq_divider_16bit: WIDTH must be 16 (shared adder is 16-bit)");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [3:0]       r_count;
  logic             r_dbz;

  logic [15:0] w_t;
  logic [15:0] w_diff;
  logic        w_msb;
  logic        w_cout;
  logic        w_ok;
  logic        w_unused_v;

  // Shift the next dividend bit into the partial remainder; the bit shifted
  // out of R is the transient 17th bit and forces a successful subtract.
  assign w_t   = {r_r[14:0], r_q[15]};
  assign w_msb = r_r[15];
  assign w_ok  = w_msb | w_cout;

  carry_lookahead_adder_16bit u_sub (
    .i_in0  (w_t),
    .i_in1  (r_d),
    .i_sub  (1'b1),
    .i_cin  (1'b0),
    .o_sum  (w_diff),
    .o_cout (w_cout),
    .o_v    (w_unused_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_count <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_q     <= DIV_BYZERO_Q;
              r_r     <= bus.dividend;
              r_dbz   <= 1'b1;
              r_state <= c_ST_DONE;
            end else begin
              r_q     <= bus.dividend;
              r_r     <= '0;
              r_d     <= bus.divisor;
              r_count <= '0;
              r_dbz   <= 1'b0;
              r_state <= c_ST_RUN;
            end
          end
        end
        c_ST_RUN: begin
          r_r     <= w_ok ? w_diff : w_t;
          r_q     <= {r_q[14:0], w_ok};
          r_count <= r_count + 4'd1;
          if (r_count == c_LAST_ITER) begin
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (r_state != c_ST_IDLE);
  assign bus.done        = (r_state == c_ST_DONE);
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: doc/seq_divider_16bit.md
# seq_divider_16bit

Sequential 16-bit unsigned restoring divider with one shared carry-lookahead subtractor. It produces one quotient bit per clock and uses a start/busy/done handshake. It sits in the Division datapath between the operand registers and the result consumer, and is the controller that sequences `carry_lookahead_adder_16bit` in subtract mode.

## Interface
- `WIDTH`, 16, operand width. Fixed at 16 because the shared adder is 16-bit; any other value is a synthesis error.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a division. Sampled only in IDLE.
- `dividend` input 16: numerator, captured on the accepted `start`.
- `divisor` input 16: denominator, captured on the accepted `start`.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse when the results are valid.
- `quotient` output 16: result, held until the next accepted `start`.
- `remainder` output 16: result, held until the next accepted `start`.
- `div_by_zero` output 1: set with `done` when `divisor == 0`; held with the results.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding lives in the package.
- **IDLE, `start` = 1, divisor ≠ 0:**
  - load Q ← dividend, R ← 0, D ← divisor, count ← 0, `div_by_zero` ← 0.
  - go to RUN.
- **IDLE, `start` = 1, divisor = 0:**
  - Q ← 16'hFFFF, R ← dividend, `div_by_zero` ← 1.
  - go directly to DONE.
- **RUN, each cycle:**
  - form t = {R[14:0], Q[15]}; msb = R[15].
  - the adder computes t − D with sub = 1, cin = 0, giving diff and cout.
  - ok = msb | cout (no borrow in the 17-bit view).
  - if ok: R ← diff; else R ← t.
  - Q ← {Q[14:0], ok}; count ← count + 1.
  - after the iteration where count = 15, go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE.
- Outputs: `quotient` = Q and `remainder` = R, driven directly from the registers.
- The remainder is always < divisor, so 16 bits suffice. The 17th bit (msb) is only transient.
- The adder's `v` output is unused. Its `cout` is the no-borrow flag.
- `start` in RUN or DONE is ignored; no queueing.
- `start` held high continuously starts a new division on every IDLE visit.
- Operand inputs are don't-care except on the accepting cycle.

## Timing
- Reset values: state IDLE; Q, R, D, count = 0; `busy` = 0; `done` = 0; `div_by_zero` = 0. So `quotient` = `remainder` = 0.
- `rst` mid-operation aborts immediately to the reset values; no `done` is produced.
- Latency for a normal divide, with `start` sampled at edge 0:
  - `busy` is high from edge 0.
  - RUN covers edges 1..16.
  - `done` is high in the cycle after edge 16 (17 cycles after the accepting edge).
  - back in IDLE after edge 17.
  - earliest next accept is edge 18, i.e. throughput is one division per 18 cycles.
- Divide-by-zero: `done` is high in the cycle after the accepting edge; `busy` is high for that one cycle only.
- `quotient`, `remainder` and `div_by_zero` are stable and valid while `done` = 1 and remain so in IDLE.
- The adder path is single-cycle combinational from registered R, Q and D. No multicycle paths.

## Structure
- Package `div_pkg` holds:
  - `div_state_t` (IDLE/RUN/DONE);
  - `DIV_WIDTH` = 16;
  - `DIV_ITERS` = 16;
  - `DIV_BYZERO_Q` = 16'hFFFF.
- One sub-module: an instance of the existing `carry_lookahead_adder_16bit`.
  - `sub` tied to 1, `cin` tied to 0.
  - in0 = t, in1 = D.
- The count register is 4 bits plus the state; no extra counter module.

## Test plan
- 100 / 7 → after 17 cycles `done` = 1, `quotient` = 14, `remainder` = 2, `div_by_zero` = 0; `busy` high for 17 cycles.
- 16'hFFFF / 16'h8001 → `quotient` = 1, `remainder` = 16'h7FFE. Exercises the msb = 1 path. Also 16'hFFFF / 1 → 16'hFFFF, 0.
- 5 / 9 → `quotient` = 0, `remainder` = 5. Also 0 / 3 → 0, 0.
- 1234 / 0 → `done` on the cycle after accept, `quotient` = 16'hFFFF, `remainder` = 1234, `div_by_zero` = 1; a following 10 / 3 clears the flag (→ 3, 1).
- `start` pulsed with new operands during RUN → ignored; the first result is unchanged and exactly one `done` is produced.
- `rst` asserted at RUN cycle 8 → next cycle IDLE with all outputs 0 and no `done`. A new `start` with 40000 / 300 → 133, 100.
